// File: rtl/spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================
// Module  : spsram_ctrl_pkg
// Brief   : shared state encoding and read-buffer sizing
// Revision: 1.0
// ============================================================
package spsram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int RBUF_DEPTH = 4;
  localparam int RBUF_AW    = 2;

endpackage
`default_nettype wire

// File: rtl/spsram_rbuf.sv
`default_nettype none
// ============================================================
// Module  : spsram_rbuf
// Brief   : small synchronous FIFO holding read data + last flag
// Revision: 1.0
// ============================================================
module spsram_rbuf
  import spsram_ctrl_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_rdata,
  output logic [RBUF_AW:0]   o_count,
  output logic               o_empty,
  output logic               o_full
);

  logic [WIDTH-1:0]   r_mem [RBUF_DEPTH];
  logic [RBUF_AW-1:0] r_wptr;
  logic [RBUF_AW-1:0] r_rptr;
  logic [RBUF_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RBUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (RBUF_AW+1)'(RBUF_DEPTH));

endmodule
`default_nettype wire

// File: rtl/spsram_ctrl.sv
`default_nettype none
// ============================================================
// Module  : spsram_ctrl
// Brief   : read/write burst controller for a sync-read single-port SRAM
// Revision: 1.0
// ============================================================
module spsram_ctrl
  import spsram_ctrl_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5,
  parameter int BW_LEN  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_wr,
  input  logic [BW_ADDR-1:0] i_cmd_addr,
  input  logic [BW_LEN-1:0]  i_cmd_len,
  input  logic               i_wdata_valid,
  output logic               o_wdata_ready,
  input  logic [BW_DATA-1:0] i_wdata,
  output logic               o_rdata_valid,
  input  logic               i_rdata_ready,
  output logic [BW_DATA-1:0] o_rdata,
  output logic               o_rdata_last,
  output logic               o_busy,
  output logic               o_mem_cen,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  input  logic [BW_DATA-1:0] i_mem_data
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BW_ADDR-1:0] r_addr;
  logic [BW_LEN-1:0]  r_len;
  logic [BW_LEN:0]    r_beat;
  logic [1:0]         r_pending;
  logic               r_rd_vld;
  logic               r_rd_last;
  logic [RBUF_AW:0]   w_buf_count;
  logic [RBUF_AW:0]   w_inflight;
  logic               w_buf_empty;
  logic               w_buf_full;
  logic [BW_DATA:0]   w_buf_out;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_credit_ok;
  logic               w_wr_beat;
  logic               w_rd_issue;

  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_last_beat = (r_beat == {1'b0, r_len});
  // Reads in flight plus buffered data must never exceed the buffer depth.
  assign w_inflight  = w_buf_count + {{(RBUF_AW-1){1'b0}}, r_pending};
  assign w_credit_ok = (w_inflight < (RBUF_AW+1)'(RBUF_DEPTH)) & ~w_buf_full;

  always_comb begin
    w_state_nxt   = r_state;
    o_cmd_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    w_wr_beat     = 1'b0;
    w_rd_issue    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = ~i_rst;
        if (i_cmd_valid && !i_rst) w_state_nxt = i_cmd_wr ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        o_wdata_ready = 1'b1;
        w_wr_beat     = i_wdata_valid;
        if (i_wdata_valid && w_last_beat) w_state_nxt = S_IDLE;
      end
      S_READ: begin
        w_rd_issue = w_credit_ok;
        if (w_credit_ok && w_last_beat) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_pending == 2'd0 && w_buf_empty && !r_rd_vld) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_pending <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= i_cmd_addr;
        r_len  <= i_cmd_len;
        r_beat <= '0;
      end else if (o_mem_cen) begin
        r_addr <= r_addr + 1'b1;
        r_beat <= r_beat + 1'b1;
      end
      // SRAM data arrives one cycle after issue; tag it with its last flag.
      r_rd_vld  <= w_rd_issue;
      r_rd_last <= w_rd_issue & w_last_beat;
      r_pending <= r_pending + {1'b0, w_rd_issue} - {1'b0, r_rd_vld};
    end
  end

  assign o_mem_cen  = w_wr_beat | w_rd_issue;
  assign o_mem_wen  = w_wr_beat;
  assign o_mem_oen  = w_rd_issue;
  assign o_mem_addr = o_mem_cen ? r_addr : '0;
  assign o_mem_data = w_wr_beat ? i_wdata : '0;
  assign o_busy     = (r_state != S_IDLE);

  spsram_rbuf #(
    .WIDTH (BW_DATA + 1)
  ) u_rbuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_rd_vld),
    .i_wdata ({r_rd_last, i_mem_data}),
    .i_pop   (o_rdata_valid & i_rdata_ready),
    .o_rdata (w_buf_out),
    .o_count (w_buf_count),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full)
  );

  assign o_rdata_valid = ~w_buf_empty;
  assign o_rdata       = w_buf_out[BW_DATA-1:0];
  assign o_rdata_last  = w_buf_out[BW_DATA];

endmodule
`default_nettype wire

// File: doc/spsram_ctrl.md
Name: spsram_ctrl

Overview:
Burst request controller placed directly upstream of the 32x32 single-port SRAM (synchronous-read build). It accepts read/write burst commands on a valid/ready interface and streams write data in and read data out. It generates the SRAM cen/wen/oen/addr/data pins and absorbs the SRAM's 1-cycle registered read latency. A small read buffer applies backpressure without losing data.

Parameters:
BW_DATA, 32, data width; must match the SRAM.
BW_ADDR, 5, address width; must match the SRAM; addresses wrap modulo 2**BW_ADDR.
BW_LEN, 4, burst length field width; a burst has i_cmd_len+1 beats (1..16).

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_wr  in  1  1=write burst, 0=read burst
i_cmd_addr  in  BW_ADDR  start address
i_cmd_len  in  BW_LEN  beats minus one
i_wdata_valid  in  1  write beat valid
o_wdata_ready  out  1  write beat consumed when valid&ready
i_wdata  in  BW_DATA  write beat data
o_rdata_valid  out  1  read beat valid
i_rdata_ready  in  1  read beat consumer ready
o_rdata  out  BW_DATA  read beat data
o_rdata_last  out  1  final beat of the read burst
o_busy  out  1  high whenever state != IDLE
o_mem_cen, o_mem_wen, o_mem_oen  out  1 each  SRAM control pins
o_mem_addr  out  BW_ADDR  SRAM address
o_mem_data  out  BW_DATA  SRAM write data
i_mem_data  in  BW_DATA  SRAM registered read data

Behaviour:
- Reset (async, i_rst=1): state IDLE; counters, pending count and read buffer cleared. All outputs 0: cmd_ready=0 while in reset, then 1 in IDLE. A burst in progress is abandoned. SRAM contents are untouched.
- States:
  - IDLE: o_cmd_ready=1; on handshake, latch addr/len/wr and go to WRITE or READ.
  - WRITE: o_wdata_ready=1. On each beat, the same cycle drives cen=1, wen=1, oen=0, addr=cur, data=i_wdata, then addr+1 (wrap) and beat+1. After the last beat, go to IDLE. No beat means cen=0, so gaps are allowed.
  - READ: issue one read per cycle (cen=1, wen=0, oen=1, addr=cur) only when buf_count+pending < 4. After the last issue, go to DRAIN.
  - DRAIN: no issues. Go to IDLE when pending=0 and buf_count=0 and the last beat has been handed off.
- Idle SRAM pins: cen=0, wen=0, oen=0, addr and data hold 0.
- Read pipeline:
  - Issue in cycle t; i_mem_data is valid in cycle t+1 and written into the buffer at the end of t+1; o_rdata_valid can be high in t+2.
  - Minimum command-to-first-data latency is 3 cycles (handshake cycle 0, issue cycle 1, data out cycle 3).
  - pending counts issued-but-not-captured reads (0..2).
  - Read buffer: 4-entry FIFO; head drives o_rdata. Simultaneous push and pop keeps count unchanged.
  - The credit rule guarantees the buffer never overflows. Full throughput (1 beat/cycle) is sustained when i_rdata_ready stays high.
- o_rdata_last is high with the beat whose burst index equals len; it is stored alongside data in the buffer.
- Address wrap: 2**BW_ADDR-1 is followed by 0. Burst length arithmetic runs in BW_LEN+1 bits.
- Back-to-back commands: the next command is accepted only in IDLE, so there is a 1-cycle gap minimum after a write and after a read drain.
- o_rdata, o_rdata_last and o_mem_data are don't-care when the corresponding valid/cen is low. The bench must not check them then.

Decomposition:
- Package spsram_ctrl_pkg holds:
  - state encoding S_IDLE=0, S_WRITE=1, S_READ=2, S_DRAIN=3;
  - RBUF_DEPTH=4 and RBUF_AW=2.
- One sub-module, spsram_rbuf: a synchronous FIFO, width BW_DATA+1 (data plus last flag), depth RBUF_DEPTH, with push, pop, count, empty and full. It uses the same clock and async reset.

Test Plan:
- Write burst addr=2, len=3, data 0xA0..0xA3, then read addr=2, len=3 with ready=1 -> read beats 0xA0,0xA1,0xA2,0xA3; last only on 0xA3; first valid 3 cycles after the read handshake; one beat per cycle after that.
- Wrap: write addr=30, len=3 data 1,2,3,4 -> o_mem_addr sequence 30,31,0,1. Read back at 30 -> 1,2,3,4.
- Read backpressure: len=15 with i_rdata_ready toggled 1-in-3 -> all 16 beats in order, none lost or duplicated; issue stalls whenever buf_count+pending=4.
- Write gaps: i_wdata_valid low for 2 cycles mid-burst -> cen=0 during the gaps; addresses stay contiguous; readback matches.
- Reset: assert i_rst during beat 2 of a read burst -> next cycle o_rdata_valid=0, o_busy=0, o_mem_cen=0. After release, a new command is accepted and earlier written data is intact.
- Busy guard: i_cmd_valid held during a write burst -> o_cmd_ready=0 until IDLE; the held command is accepted in the first IDLE cycle.
